// File: rtl/fpu8_issue_ctrl.sv
// rtl/fpu8_issue_ctrl.sv - E4M3 FPU issue/result stage: exception resolve, core dispatch, timeout, sticky flags
module fpu8_issue_ctrl #(
    parameter int unsigned TIMEOUT   = 15,
    parameter logic [7:0]  NAN_0     = 8'h7F,
    parameter logic [2:0]  DIVZ_EXCE = 3'd4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [1:0] req_op_i,
    input  logic [7:0] req_a_i,
    input  logic [7:0] req_b_i,
    output logic [1:0] exc_op_o,
    output logic [7:0] exc_a_o,
    output logic [7:0] exc_b_o,
    input  logic       exc_caught_i,
    input  logic [2:0] exc_code_i,
    output logic       core_start_o,
    output logic [1:0] core_op_o,
    output logic [7:0] core_a_o,
    output logic [7:0] core_b_o,
    input  logic       core_done_i,
    input  logic [7:0] core_result_i,
    output logic       res_valid_o,
    input  logic       res_ready_i,
    output logic [7:0] res_data_o,
    output logic       res_exc_o,
    output logic [2:0] res_code_o,
    output logic       res_timeout_o,
    output logic [7:0] sticky_flags_o,
    output logic       sticky_tmo_o,
    input  logic       flags_clear_i
);
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EXEC, S_DONE} state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [7:0] a_q, a_d, b_q, b_d;
    logic       start_q, start_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0] res_data_q, res_data_d;
    logic       res_exc_q, res_exc_d;
    logic [2:0] res_code_q, res_code_d;
    logic       res_tmo_q, res_tmo_d;
    logic [7:0] sticky_q, sticky_d;
    logic       sticky_tmo_q, sticky_tmo_d;

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        start_d      = 1'b0;
        cnt_d        = cnt_q;
        res_data_d   = res_data_q;
        res_exc_d    = res_exc_q;
        res_code_d   = res_code_q;
        res_tmo_d    = res_tmo_q;
        // A flag set on the same edge as a clear overrides the clear for that bit only.
        sticky_d     = flags_clear_i ? 8'h00 : sticky_q;
        sticky_tmo_d = flags_clear_i ? 1'b0 : sticky_tmo_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (exc_caught_i) begin
                    state_d    = S_DONE;
                    res_exc_d  = 1'b1;
                    res_code_d = exc_code_i;
                    res_tmo_d  = 1'b0;
                    res_data_d = (exc_code_i == DIVZ_EXCE) ? {a_q[7] ^ b_q[7], 7'h78} : NAN_0;
                    sticky_d[exc_code_i] = 1'b1;
                end else begin
                    state_d = S_EXEC;
                    start_d = 1'b1;
                    cnt_d   = 8'd0;
                end
            end
            S_EXEC: begin
                // core_done during the start pulse belongs to nothing we issued.
                if (core_done_i && !start_q) begin
                    state_d    = S_DONE;
                    res_data_d = core_result_i;
                    res_exc_d  = 1'b0;
                    res_code_d = 3'd0;
                    res_tmo_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO_LIMIT) begin
                        state_d      = S_DONE;
                        res_data_d   = NAN_0;
                        res_exc_d    = 1'b0;
                        res_code_d   = 3'd0;
                        res_tmo_d    = 1'b1;
                        sticky_tmo_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            op_q         <= 2'd0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            start_q      <= 1'b0;
            cnt_q        <= 8'd0;
            res_data_q   <= 8'd0;
            res_exc_q    <= 1'b0;
            res_code_q   <= 3'd0;
            res_tmo_q    <= 1'b0;
            sticky_q     <= 8'd0;
            sticky_tmo_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            start_q      <= start_d;
            cnt_q        <= cnt_d;
            res_data_q   <= res_data_d;
            res_exc_q    <= res_exc_d;
            res_code_q   <= res_code_d;
            res_tmo_q    <= res_tmo_d;
            sticky_q     <= sticky_d;
            sticky_tmo_q <= sticky_tmo_d;
        end
    end

    assign req_ready_o    = (state_q == S_IDLE);
    assign res_valid_o    = (state_q == S_DONE);
    assign exc_op_o       = op_q;
    assign exc_a_o        = a_q;
    assign exc_b_o        = b_q;
    assign core_op_o      = op_q;
    assign core_a_o       = a_q;
    assign core_b_o       = b_q;
    assign core_start_o   = start_q;
    assign res_data_o     = res_data_q;
    assign res_exc_o      = res_exc_q;
    assign res_code_o     = res_code_q;
    assign res_timeout_o  = res_tmo_q;
    assign sticky_flags_o = sticky_q;
    assign sticky_tmo_o   = sticky_tmo_q;
endmodule

// File: tb/tb_fpu8_issue_ctrl.sv
// tb/tb_fpu8_issue_ctrl.sv - self-checking bench for fpu8_issue_ctrl
module tb_fpu8_issue_ctrl;
    localparam int TMO = 4;
    localparam logic [7:0] NAN0 = 8'h7F;
    localparam logic [2:0] C_SNAN = 3'd1;
    localparam logic [2:0] C_DIVZ = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid_i, req_ready_o;
    logic [1:0] req_op_i;
    logic [7:0] req_a_i, req_b_i;
    logic [1:0] exc_op_o;
    logic [7:0] exc_a_o, exc_b_o;
    logic       exc_caught_i;
    logic [2:0] exc_code_i;
    logic       core_start_o;
    logic [1:0] core_op_o;
    logic [7:0] core_a_o, core_b_o;
    logic       core_done_i;
    logic [7:0] core_result_i;
    logic       res_valid_o, res_ready_i;
    logic [7:0] res_data_o;
    logic       res_exc_o;
    logic [2:0] res_code_o;
    logic       res_timeout_o;
    logic [7:0] sticky_flags_o;
    logic       sticky_tmo_o;
    logic       flags_clear_i;

    fpu8_issue_ctrl #(.TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .exc_op_o(exc_op_o), .exc_a_o(exc_a_o), .exc_b_o(exc_b_o),
        .exc_caught_i(exc_caught_i), .exc_code_i(exc_code_i),
        .core_start_o(core_start_o), .core_op_o(core_op_o), .core_a_o(core_a_o), .core_b_o(core_b_o),
        .core_done_i(core_done_i), .core_result_i(core_result_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_exc_o(res_exc_o), .res_code_o(res_code_o), .res_timeout_o(res_timeout_o),
        .sticky_flags_o(sticky_flags_o), .sticky_tmo_o(sticky_tmo_o), .flags_clear_i(flags_clear_i)
    );

    always #5 clk = ~clk;

    function automatic bit is_nan(input logic [7:0] x);
        return x[6:0] == 7'h7F;
    endfunction

    // Stand-in for EXCEPTION_MODULE: NaN operands beat divide-by-zero.
    logic exc_nan, exc_divz;
    assign exc_nan      = is_nan(exc_a_o) || is_nan(exc_b_o);
    assign exc_divz     = (exc_op_o == 2'd3) && (exc_b_o[6:0] == 7'd0);
    assign exc_caught_i = exc_nan || exc_divz;
    assign exc_code_i   = exc_nan ? C_SNAN : (exc_divz ? C_DIVZ : 3'd0);

    // Core model: cfg_dly>0 answers that many cycles after the start cycle,
    // 0 answers only inside the start cycle, <0 never answers.
    int         cfg_dly = -1;
    logic [7:0] cfg_val = 8'h00;
    int         cd;
    initial begin
        core_done_i   = 1'b0;
        core_result_i = 8'h00;
        cd = -1;
        forever begin
            @(negedge clk);
            core_done_i = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    core_done_i   = 1'b1;
                    core_result_i = cfg_val;
                    cd = -1;
                end
            end
            if (core_start_o) begin
                if (cfg_dly == 0) begin
                    core_done_i   = 1'b1;
                    core_result_i = cfg_val;
                end else if (cfg_dly > 0) begin
                    cd = cfg_dly;
                end
            end
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         dly;
        logic [7:0] val;
        int         hold;
        bit         clr;
        logic [7:0] e_data;
        bit         e_exc;
        logic [2:0] e_code;
        bit         e_tmo;
        int         e_lat;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_sticky = 8'h00;
    bit         exp_tmo = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                input int dly, input logic [7:0] val, input int hold, input bit clr,
                                input logic [7:0] e_data, input bit e_exc, input logic [2:0] e_code,
                                input bit e_tmo, input int e_lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.dly = dly; v.val = val; v.hold = hold; v.clr = clr;
        v.e_data = e_data; v.e_exc = e_exc; v.e_code = e_code; v.e_tmo = e_tmo; v.e_lat = e_lat;
        return v;
    endfunction

    // Reference: exceptions resolve 2 cycles after the request cycle; a core answer d cycles
    // after start lands at 3+d if it arrives within the TMO-cycle window, else timeout at 2+TMO.
    function automatic vec_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input int dly, input logic [7:0] val, input int hold, input bit clr);
        if (is_nan(a) || is_nan(b))
            return mk(op, a, b, dly, val, hold, clr, NAN0, 1, C_SNAN, 0, 2);
        if (op == 2'd3 && b[6:0] == 7'd0)
            return mk(op, a, b, dly, val, hold, clr, {a[7] ^ b[7], 7'h78}, 1, C_DIVZ, 0, 2);
        if (dly >= 1 && dly <= TMO - 1)
            return mk(op, a, b, dly, val, hold, clr, val, 0, 3'd0, 0, 3 + dly);
        return mk(op, a, b, dly, val, hold, clr, NAN0, 0, 3'd0, 1, 2 + TMO);
    endfunction

    task automatic run_txn(input vec_t v);
        int lat;
        int starts;
        cfg_dly = v.dly;
        cfg_val = v.val;
        check("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1'b1; req_op_i = v.op; req_a_i = v.a; req_b_i = v.b;
        @(negedge clk);
        req_valid_i = 1'b0;
        req_a_i = 8'($urandom);
        req_b_i = 8'($urandom);
        if (v.clr) flags_clear_i = 1'b1;
        lat = 1;
        starts = 0;
        while (!res_valid_o && lat < 40) begin
            if (core_start_o) begin
                starts++;
                check("core_a", core_a_o, v.a);
                check("core_op", core_op_o, v.op);
            end
            @(negedge clk);
            flags_clear_i = 1'b0;
            lat++;
        end
        flags_clear_i = 1'b0;
        check("latency", lat, v.e_lat);
        check("res_data", res_data_o, v.e_data);
        check("res_exc", res_exc_o, v.e_exc);
        check("res_code", res_code_o, v.e_code);
        check("res_timeout", res_timeout_o, v.e_tmo);
        check("core_starts", starts, v.e_exc ? 0 : 1);
        if (v.clr) begin
            exp_sticky = 8'h00;
            exp_tmo = 1'b0;
        end
        if (v.e_exc) exp_sticky[v.e_code] = 1'b1;
        if (v.e_tmo) exp_tmo = 1'b1;
        check("sticky_flags", sticky_flags_o, exp_sticky);
        check("sticky_tmo", sticky_tmo_o, exp_tmo);
        for (int h = 0; h < v.hold; h++) begin
            req_valid_i = 1'b1;
            req_a_i = 8'($urandom);
            @(negedge clk);
            check("hold_valid", res_valid_o, 1);
            check("hold_data", res_data_o, v.e_data);
            check("hold_ready", req_ready_o, 0);
            check("hold_latched", exc_a_o, v.a);
        end
        req_valid_i = 1'b0;
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        check("post_valid", res_valid_o, 0);
        check("post_ready", req_ready_o, 1);
    endtask

    vec_t vecs[11];

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_op_i = 2'd0; req_a_i = 8'h00; req_b_i = 8'h00;
        res_ready_i = 1'b0; flags_clear_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", req_ready_o, 1);
        check("rst_res_valid", res_valid_o, 0);
        check("rst_core_start", core_start_o, 0);
        check("rst_sticky", sticky_flags_o, 0);
        check("rst_sticky_tmo", sticky_tmo_o, 0);
        check("rst_res_data", res_data_o, 0);
        check("rst_res_code", res_code_o, 0);
        check("rst_res_flags", {res_exc_o, res_timeout_o}, 0);
        check("rst_exc_ops", {exc_op_o, exc_a_o, exc_b_o}, 0);

        vecs[0]  = mk(2'd0, 8'h38, 8'h38,  3, 8'h40, 0, 0, 8'h40, 0, 3'd0,   0, 6);
        vecs[1]  = mk(2'd0, 8'h7F, 8'h00, -1, 8'h00, 0, 0, 8'h7F, 1, C_SNAN, 0, 2);
        vecs[2]  = mk(2'd1, 8'h7F, 8'h00, -1, 8'h00, 0, 0, 8'h7F, 1, C_SNAN, 0, 2);
        vecs[3]  = mk(2'd2, 8'h7F, 8'h00, -1, 8'h00, 0, 0, 8'h7F, 1, C_SNAN, 0, 2);
        vecs[4]  = mk(2'd3, 8'h7F, 8'h00, -1, 8'h00, 0, 0, 8'h7F, 1, C_SNAN, 0, 2);
        vecs[5]  = mk(2'd3, 8'hB8, 8'h00, -1, 8'h00, 0, 1, 8'hF8, 1, C_DIVZ, 0, 2);
        vecs[6]  = mk(2'd2, 8'h40, 8'h40, -1, 8'h00, 0, 0, 8'h7F, 0, 3'd0,   1, 6);
        vecs[7]  = mk(2'd1, 8'h48, 8'h38,  1, 8'h3C, 5, 0, 8'h3C, 0, 3'd0,   0, 4);
        vecs[8]  = mk(2'd3, 8'h38, 8'h38,  4, 8'h55, 0, 0, 8'h7F, 0, 3'd0,   1, 6);
        vecs[9]  = mk(2'd3, 8'h38, 8'h80, -1, 8'h00, 0, 0, 8'hF8, 1, C_DIVZ, 0, 2);
        vecs[10] = mk(2'd0, 8'h30, 8'h28,  0, 8'h11, 0, 0, 8'h7F, 0, 3'd0,   1, 6);
        for (int i = 0; i < 11; i++) run_txn(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            case ($urandom_range(0, 5))
                0: ra = 8'h7F;
                1: ra = 8'hFF;
                2: ra = 8'h00;
                default: ra = 8'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: rb = 8'h00;
                1: rb = 8'h80;
                2: rb = 8'hFF;
                default: rb = 8'($urandom);
            endcase
            run_txn(model(2'($urandom_range(0, 3)), ra, rb, $urandom_range(0, 6) - 1,
                          8'($urandom), $urandom_range(0, 2), $urandom_range(0, 7) == 0));
        end

        flags_clear_i = 1'b1;
        @(negedge clk);
        flags_clear_i = 1'b0;
        exp_sticky = 8'h00;
        exp_tmo = 1'b0;
        check("idle_clear_flags", sticky_flags_o, 0);
        check("idle_clear_tmo", sticky_tmo_o, 0);

        run_txn(mk(2'd3, 8'h38, 8'h00, -1, 8'h00, 0, 0, 8'h78, 1, C_DIVZ, 0, 2));
        cfg_dly = 3;
        cfg_val = 8'h66;
        req_valid_i = 1'b1; req_op_i = 2'd0; req_a_i = 8'h38; req_b_i = 8'h38;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        check("mid_start_seen", core_start_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_sticky = 8'h00;
        check("mid_rst_sticky", sticky_flags_o, exp_sticky);
        for (int k = 0; k < 6; k++) begin
            check("mid_rst_valid", res_valid_o, 0);
            check("mid_rst_ready", req_ready_o, 1);
            check("mid_rst_start", core_start_o, 0);
            @(negedge clk);
        end
        run_txn(mk(2'd2, 8'h40, 8'h38, 2, 8'h48, 1, 0, 8'h48, 0, 3'd0, 0, 5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
